// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 7-segment scanner with ghost guard; `define SEG7_SCAN_LZB_EN for leading-zero blanking
module seg7_scan #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV = 50000
) (
   input logic clk,
   input logic reset,
   input logic en,
   input logic load,
   input logic [4*NUM_DIGITS-1:0] digits,
   output logic [6:0] seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic frame_tick
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [3:0] shadow [NUM_DIGITS];
   logic [3:0] code;
   logic last_cnt;
   logic last_idx;
   logic show;
   assign last_cnt = cnt == CW'(SCAN_DIV - 1);
   assign last_idx = idx == IW'(NUM_DIGITS - 1);
   assign show = en && cnt != '0;
   function automatic logic [6:0] decode(input logic [3:0] c);
      case (c)
         4'd0: decode = 7'b1000000;
         4'd1: decode = 7'b1111001;
         4'd2: decode = 7'b0100100;
         4'd3: decode = 7'b0110000;
         4'd4: decode = 7'b0011001;
         4'd5: decode = 7'b0010010;
         4'd6: decode = 7'b0000010;
         4'd7: decode = 7'b1111000;
         4'd8: decode = 7'b0000000;
         4'd9: decode = 7'b0010000;
         4'd11: decode = 7'b0111111;
         default: decode = 7'b1111111;
      endcase
   endfunction
`ifdef SEG7_SCAN_LZB_EN
   logic [NUM_DIGITS-1:0] sup;
   // a zero digit is suppressed while every digit above it is zero or blank; digit 0 always shows
   always_comb begin
      logic lead;
      lead = 1'b1;
      sup = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         sup[i] = lead && shadow[i] == 4'd0;
         lead = lead && (shadow[i] == 4'd0 || shadow[i] == 4'd10);
      end
   end
   assign code = sup[idx] ? 4'd10 : shadow[idx];
`else
   assign code = shadow[idx];
`endif
   // prescaler, digit index, shadow capture and registered outputs (outputs use pre-edge shadow, so loads never tear)
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         idx <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= 4'd10;
         an <= '1;
         seg <= '1;
         frame_tick <= 1'b0;
      end else begin
         if (load) for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= digits[4*i +: 4];
         if (en) begin
            cnt <= last_cnt ? '0 : cnt + 1'b1;
            if (last_cnt) idx <= last_idx ? '0 : idx + 1'b1;
         end
         an <= show ? ~(NUM_DIGITS'(1) << idx) : '1;
         seg <= show ? decode(code) : 7'b1111111;
         frame_tick <= en && last_cnt && last_idx;
      end
   end
endmodule
